reload_sched: RTL and testbench
===============================

RELOAD_SCHED -- requirements
Module: reload_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the self-reloading counter.
REQ-002 Parameter DATA_W, default 4, width of counter load value and count.
REQ-003 Parameter WINDOW, default 3, number of RUN cycles (>=1) a granted requester owns the counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately, release sampled on clk.
REQ-006 req_i  input  NUM_REQ  per-requester level request; held until gnt_o bit seen.
REQ-007 val_i  input  NUM_REQ*DATA_W  per-requester load value; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 count_i  input  DATA_W  current count from the counter.
REQ-009 load_o  output  1  load strobe to counter load_i.
REQ-010 load_val_o  output  DATA_W  value to counter load_val_i.
REQ-011 gnt_o  output  NUM_REQ  one-hot grant pulse.
REQ-012 done_o  output  NUM_REQ  one-hot completion pulse to owner.
REQ-013 result_o  output  DATA_W  count captured at end of window.
REQ-014 mismatch_o  output  1  result differs from expected; valid with done_o.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-017 IDLE: if any req_i bit high, pick winner round-robin, latch owner index and val_i slice, go LOAD next cycle; else stay.
REQ-018 Round-robin: search starts at index ptr, ascending with wrap; after grant to i, ptr = (i+1) mod NUM_REQ.
REQ-019 req_i sampled only in IDLE; requests asserted/dropped in other states have no effect until IDLE.
REQ-020 LOAD (exactly 1 cycle): load_o=1, load_val_o=latched value, gnt_o[owner]=1; next state RUN.
REQ-021 load_o and gnt_o are 0 in every state except LOAD; load_val_o holds last loaded value otherwise.
REQ-022 RUN lasts exactly WINDOW cycles, tracked by internal cycle counter (k=0..WINDOW-1); count_i expected val+k mod 2^DATA_W.
REQ-023 On last RUN cycle: result_o <= count_i; mismatch_o <= (count_i != (val+WINDOW-1) mod 2^DATA_W); next state DONE.
REQ-024 DONE (1 cycle): done_o[owner]=1; result_o/mismatch_o stable until next DONE; next state IDLE.
REQ-025 Arithmetic for expected value is modulo 2^DATA_W (wraps, no saturation).
REQ-026 Grant-to-grant minimum spacing: WINDOW+3 cycles (LOAD, WINDOW RUN, DONE, IDLE).
REQ-027 A requester holding req_i after its done_o is re-arbitrated at lowest priority relative to other pending requesters.

Reset
REQ-028 reset=0 (any time, incl. mid-RUN): state=IDLE, ptr=0, load_o=0, load_val_o=0, gnt_o=0, done_o=0, result_o=0, mismatch_o=0, busy_o=0, internal counters 0.
REQ-029 Reset mid-operation aborts the transaction with no done_o; first IDLE cycle after release may grant.

Verification
REQ-030 Single request: req_i=4'b0010, val slice1=4'h5, counter correct -> gnt_o=4'b0010 with load_o=1, load_val_o=5; 3 RUN cycles; done_o=4'b0010, result_o=7, mismatch_o=0.
REQ-031 Contention: req_i=4'b1111 held, vals 1,2,3,4 -> grant order 0,1,2,3,0; results 3,4,5,6; grants spaced 6 cycles.
REQ-032 Wrap: val=4'hE, WINDOW=3 -> result_o=0, mismatch_o=0.
REQ-033 Faulty counter model (stuck at loaded value 9) -> result_o=9, mismatch_o=1, done_o still pulses.
REQ-034 Reset asserted during RUN cycle 1 -> all outputs 0 immediately, no done_o; after release, pending req_i=4'b1000 granted with ptr restarted at 0.
REQ-035 Request dropped during RUN by non-owner (req_i 4'b0101 -> 4'b0001 mid-window) -> next grant only to requester 0; never gnt_o[2].

Source files
------------

// File: rtl/reload_sched.sv
// reload_sched: round-robin scheduler that lends one self-reloading counter
// to NUM_REQ requesters. A winner gets a one-cycle load (LOAD), owns the
// counter for WINDOW cycles (RUN), and then receives a completion pulse
// together with the captured count and a mismatch flag (DONE).
//
// Handshake: req_i[i] is a level request sampled only in IDLE. The
// requester keeps it high until it sees its gnt_o bit. gnt_o and done_o are
// single-cycle pulses with no back-pressure. result_o and mismatch_o are
// valid while done_o is high and hold their values until the next DONE.
module reload_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int WINDOW  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] val_i,
    input  logic [DATA_W-1:0]         count_i,
    output logic                      load_o,
    output logic [DATA_W-1:0]         load_val_o,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         result_o,
    output logic                      mismatch_o,
    output logic                      busy_o,
    output logic [1:0]                dbg_state_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int K_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [PTR_W-1:0]    ptr, ptr_d;
    logic [PTR_W-1:0]    owner, owner_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [K_W-1:0]      k, k_d;

    logic                load_d;
    logic [DATA_W-1:0]   load_val_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [NUM_REQ-1:0]  done_d;
    logic [DATA_W-1:0]   result_d;
    logic                mismatch_d;
    logic                busy_d;

    logic                found;
    logic [PTR_W-1:0]    win;
    logic [DATA_W-1:0]   win_val;

    assign dbg_state_o = state;

    // Round-robin search: first asserted request at or after ptr, with wrap.
    always_comb begin
        int idx;
        found   = 1'b0;
        win     = '0;
        win_val = '0;
        idx     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = (int'(ptr) + j) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                win     = PTR_W'(idx);
                win_val = val_i[idx*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        owner_d    = owner;
        val_d      = val_q;
        k_d        = k;
        load_d     = 1'b0;
        load_val_d = load_val_o;
        gnt_d      = '0;
        done_d     = '0;
        result_d   = result_o;
        mismatch_d = mismatch_o;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d    = LOAD;
                    owner_d    = win;
                    val_d      = win_val;
                    load_d     = 1'b1;
                    load_val_d = win_val;
                    gnt_d      = NUM_REQ'(1) << win;
                    // The winner drops to lowest priority for the next search.
                    if (int'(win) == NUM_REQ - 1) ptr_d = '0;
                    else                          ptr_d = win + 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
                k_d     = '0;
            end
            RUN: begin
                if (k == K_W'(WINDOW - 1)) begin
                    state_d    = DONE;
                    result_d   = count_i;
                    mismatch_d = (count_i != DATA_W'(val_q + DATA_W'(WINDOW - 1)));
                    done_d     = NUM_REQ'(1) << owner;
                end else begin
                    k_d = k + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            val_q      <= '0;
            k          <= '0;
            load_o     <= 1'b0;
            load_val_o <= '0;
            gnt_o      <= '0;
            done_o     <= '0;
            result_o   <= '0;
            mismatch_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            owner      <= owner_d;
            val_q      <= val_d;
            k          <= k_d;
            load_o     <= load_d;
            load_val_o <= load_val_d;
            gnt_o      <= gnt_d;
            done_o     <= done_d;
            result_o   <= result_d;
            mismatch_o <= mismatch_d;
            busy_o     <= busy_d;
        end
    end

endmodule

// File: tb/tb_reload_sched.sv
// Directed bench for reload_sched with a behavioural counter attached to
// load_o/load_val_o/count_i. The counter can be frozen to emulate a fault.
module tb_reload_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int WINDOW  = 3;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] val_i;
    logic [DATA_W-1:0]         count_i;
    logic                      load_o;
    logic [DATA_W-1:0]         load_val_o;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [DATA_W-1:0]         result_o;
    logic                      mismatch_o;
    logic                      busy_o;
    logic [1:0]                dbg_state_o;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_gnt = 0;
    logic stuck  = 1'b0;
    logic [DATA_W-1:0] cnt;

    reload_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .val_i       (val_i),
        .count_i     (count_i),
        .load_o      (load_o),
        .load_val_o  (load_val_o),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .mismatch_o  (mismatch_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external self-reloading counter model (optionally stuck)
    always @(posedge clk) begin
        if (load_o)      cnt <= load_val_o;
        else if (!stuck) cnt <= cnt + 1'b1;
    end
    assign count_i = cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_load"},     32'(load_o),      32'd0);
        chk({tag, "_loadval"},  32'(load_val_o),  32'd0);
        chk({tag, "_gnt"},      32'(gnt_o),       32'd0);
        chk({tag, "_done"},     32'(done_o),      32'd0);
        chk({tag, "_result"},   32'(result_o),    32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch_o),  32'd0);
        chk({tag, "_busy"},     32'(busy_o),      32'd0);
        chk({tag, "_state"},    32'(dbg_state_o), 32'd0);
    endtask

    // Wait (bounded) for a grant at a falling edge, then follow the
    // transaction through LOAD, RUN and DONE. exp_gap=0 skips spacing.
    task automatic txn(input string tag, input logic [3:0] exp_gnt,
                       input logic [3:0] exp_val, input logic [3:0] exp_res,
                       input logic exp_mm, input int exp_gap);
        int n;
        n = 0;
        while (gnt_o == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
        end else begin
            chk({tag, "_gnt"},     32'(gnt_o),      32'(exp_gnt));
            chk({tag, "_load"},    32'(load_o),     32'd1);
            chk({tag, "_loadval"}, 32'(load_val_o), 32'(exp_val));
            chk({tag, "_busy"},    32'(busy_o),     32'd1);
            if (exp_gap != 0) chk({tag, "_gap"}, 32'(cyc - last_gnt), 32'(exp_gap));
            last_gnt = cyc;
            @(negedge clk);
            chk({tag, "_run_load"}, 32'(load_o), 32'd0);
            chk({tag, "_run_gnt"},  32'(gnt_o),  32'd0);
            chk({tag, "_run_hold"}, 32'(load_val_o), 32'(exp_val));
            repeat (WINDOW) @(negedge clk);
            chk({tag, "_done"},     32'(done_o),     32'(exp_gnt));
            chk({tag, "_result"},   32'(result_o),   32'(exp_res));
            chk({tag, "_mismatch"}, 32'(mismatch_o), 32'(exp_mm));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req_i = '0;
        val_i = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // single request, slice1 = 5 -> result 7
        val_i = 16'h0050;
        req_i = 4'b0010;
        txn("single", 4'b0010, 4'h5, 4'h7, 1'b0, 0);
        req_i = '0;
        @(negedge clk);
        chk("single_idle_done", 32'(done_o), 32'd0);
        chk("single_idle_busy", 32'(busy_o), 32'd0);
        chk("single_result_hold", 32'(result_o), 32'd7);

        // contention with ptr restarted at 0: order 0,1,2,3,0, spacing 6
        do_reset();
        val_i = 16'h4321;
        req_i = 4'b1111;
        txn("rr0", 4'b0001, 4'h1, 4'h3, 1'b0, 0);
        txn("rr1", 4'b0010, 4'h2, 4'h4, 1'b0, 6);
        txn("rr2", 4'b0100, 4'h3, 4'h5, 1'b0, 6);
        txn("rr3", 4'b1000, 4'h4, 4'h6, 1'b0, 6);
        txn("rr4", 4'b0001, 4'h1, 4'h3, 1'b0, 6);
        req_i = '0;
        repeat (3) @(negedge clk);

        // wrap: E + 2 = 0 mod 16
        val_i = 16'h0E00;
        req_i = 4'b0100;
        txn("wrap", 4'b0100, 4'hE, 4'h0, 1'b0, 0);
        req_i = '0;
        repeat (3) @(negedge clk);

        // frozen counter at 9 -> result 9, mismatch set
        stuck = 1'b1;
        val_i = 16'h0009;
        req_i = 4'b0001;
        txn("stuck", 4'b0001, 4'h9, 4'h9, 1'b1, 0);
        req_i = '0;
        @(negedge clk);
        stuck = 1'b0;
        chk("stuck_mm_hold", 32'(mismatch_o), 32'd1);
        repeat (2) @(negedge clk);

        // reset during RUN cycle 1 aborts; pending 1000 granted first IDLE
        val_i = 16'h7030;
        req_i = 4'b0010;
        begin
            int n;
            n = 0;
            while (gnt_o == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("abort_gnt", 32'(gnt_o), 32'b0010);
        end
        req_i = 4'b1000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_zero("abort");
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done_o), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_regrant", 32'(gnt_o), 32'b1000);
        txn("abort_txn", 4'b1000, 4'h7, 4'h9, 1'b0, 0);
        req_i = '0;
        repeat (3) @(negedge clk);

        // non-owner drops mid-window: only requester 0 is ever granted
        val_i = 16'h0501;
        req_i = 4'b0101;
        txn("drop0", 4'b0001, 4'h1, 4'h3, 1'b0, 0);
        req_i = 4'b0001;
        txn("drop1", 4'b0001, 4'h1, 4'h3, 1'b0, 6);
        req_i = '0;
        repeat (8) begin
            @(negedge clk);
            chk("drop_no_gnt2", 32'(gnt_o[2]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
